pkt_buffer_reader: RTL and testbench
====================================

Name: pkt_buffer_reader

Overview:
- Downstream consumer of the packet-buffer/address-manager block, sitting between the PIFO dequeue side and the output AXI-Stream.
- Accepts a packet descriptor (SOP address), then drives the buffer's first-word/read-enable controls to walk the linked word chain.
- Streams the words out on AXI-Stream through a small output FIFO that absorbs downstream backpressure, and stops exactly at tlast.

Parameters:
- ADDR_WIDTH, 12, buffer word-address width.
- C_M_AXIS_DATA_WIDTH, 256, tdata width; tkeep is C_M_AXIS_DATA_WIDTH/8.
- C_M_AXIS_TUSER_WIDTH, 128, tuser width.
- OUT_FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- s_axis_desc_tdata  in  ADDR_WIDTH  SOP address of the packet to dequeue.
- s_axis_desc_tvalid  in  1  descriptor valid.
- s_axis_desc_tready  out  1  descriptor accepted.
- m_buf_rd_first_word_en  out  1  to buffer: start packet at m_buf_rd_pkt_sop_addr.
- m_buf_rd_en  out  1  to buffer: consume one word.
- m_buf_rd_pkt_sop_addr  out  ADDR_WIDTH  SOP address for the buffer.
- s_buf_tdata  in  C_M_AXIS_DATA_WIDTH  buffer read data (unregistered buffer output).
- s_buf_tkeep  in  C_M_AXIS_DATA_WIDTH/8  buffer read keep.
- s_buf_tlast  in  1  buffer read last.
- s_buf_tuser  in  C_M_AXIS_TUSER_WIDTH  buffer read metadata.
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  output stream data.
- m_axis_tkeep  out  C_M_AXIS_DATA_WIDTH/8  output stream keep.
- m_axis_tlast  out  1  output stream last.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  output stream metadata.
- m_axis_tvalid  out  1  output stream valid.
- m_axis_tready  in  1  output stream ready.
- busy  out  1  high when state is not IDLE or the FIFO is non-empty.
- pkt_count  out  32  packets fully read from the buffer.

Behaviour:
- Reset values:
  - State is IDLE; FIFO is empty; all outputs are 0; pkt_count is 0.
  - The buffer block must be reset in the same cycle.
- Read latency: a read issued in cycle t (first_word_en or rd_en) presents its word on s_buf_* in cycle t+1. That word is valid only when the inflight flag is 1.
- Admission rule:
  - occ_next = fifo_count + push - pop.
  - A read may be issued only if occ_next < OUT_FIFO_DEPTH, so a landing word always has a free slot.
- IDLE:
  - If desc_tvalid and the admission rule passes, assert desc_tready, first_word_en, rd_en and sop_addr = desc_tdata in the same cycle.
  - Set inflight=1 and go to STREAM.
  - rd_en is asserted together with first_word_en so the buffer occupancy counter decrements for word 0.
- STREAM (inflight=1):
  - Push the s_buf word into the FIFO.
  - If s_buf_tlast=1: no further read, pkt_count+1, inflight=0, go to IDLE. One bubble cycle between packets is permitted.
  - Else if the admission rule passes: assert rd_en alone (first_word_en=0), keep inflight=1.
  - Else: inflight=0, go to STALL.
- STALL:
  - When the admission rule passes, assert rd_en, set inflight=1 and go to STREAM.
  - The buffer tail pointer is still on the last word read, so rd_en fetches the next link.
- Forbidden: rd_en after the tlast word has been observed; first_word_en in any state other than IDLE.
- Output FIFO:
  - Pop when m_axis_tvalid and m_axis_tready.
  - tvalid = FIFO non-empty; first-word fall-through.
  - Simultaneous push and pop at full is legal only when a pop occurs; the admission rule guarantees no overflow.
  - Pointers wrap modulo OUT_FIFO_DEPTH; count width is clog2(OUT_FIFO_DEPTH)+1.
- pkt_count wraps modulo 2^32.
- Mid-packet reset:
  - All state is discarded and the descriptor is lost.
  - The buffer block must also be reset; no recovery of the partial packet.
- Full-rate throughput: one word per cycle while m_axis_tready=1.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE=0, STREAM=1, STALL=2;
  - default widths ADDR_WIDTH=12, data width 256, tuser width 128.
- One natural sub-module: axis_fwft_fifo.
  - Parameterised width and depth; push/pop/count/full/empty.
  - Instantiated for the {tlast, tkeep, tuser, tdata} bundle.

Test Plan:
- 3-word packet at SOP=0x010, tready=1 -> one cycle of first_word_en+rd_en, rd_en in 2 following cycles, 3 output beats, tlast on beat 3, pkt_count=1.
- Single-word packet (tlast on word 0) -> exactly one read (first_word_en+rd_en), no extra rd_en, one beat with tlast=1.
- 10-word packet, tready held 0 from cycle 2 for 8 cycles -> FIFO fills to 4, state STALL, no rd_en while full, no data loss; after release all 10 beats arrive in order.
- Back-to-back descriptors 0x020 (4 words) then 0x100 (2 words) -> second first_word_en only after tlast of the first; 6 beats total; pkt_count=2.
- tready toggling 1/0 every cycle on a 16-word packet -> beat order and data intact; FIFO count never exceeds 4.
- rst asserted asynchronously mid-packet -> all outputs 0 immediately; FSM in IDLE; FIFO empty; pkt_count=0.

Source files
------------

// File: rtl/pkt_buffer_reader_pkg.sv
// Shared types and default widths for the packet buffer reader.
package pkt_buffer_reader_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 12;
  localparam int unsigned DEF_DATA_WIDTH  = 256;
  localparam int unsigned DEF_TUSER_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    STALL  = 2'd2
  } state_t;

endpackage

// File: rtl/pkt_buffer_reader_if.sv
// Output AXI-Stream bundle of the packet buffer reader.
interface pkt_buffer_reader_if #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_fwft_fifo.sv
// First-word fall-through FIFO; dout reads as zero while empty.
module axis_fwft_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage write; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/pkt_buffer_reader.sv
// Walks a packet's word chain in the buffer and streams it out via a FWFT FIFO.
module pkt_buffer_reader
  import pkt_buffer_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH           = DEF_ADDR_WIDTH,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int unsigned OUT_FIFO_DEPTH       = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ADDR_WIDTH-1:0]               s_axis_desc_tdata,
  input  logic                                s_axis_desc_tvalid,
  output logic                                s_axis_desc_tready,
  output logic                                m_buf_rd_first_word_en,
  output logic                                m_buf_rd_en,
  output logic [ADDR_WIDTH-1:0]               m_buf_rd_pkt_sop_addr,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]      s_buf_tdata,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]    s_buf_tkeep,
  input  logic                                s_buf_tlast,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]     s_buf_tuser,
  pkt_buffer_reader_if.master                 m_axis,
  output logic                                busy,
  output logic [31:0]                         pkt_count
);
  localparam int unsigned KW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned FW = 1 + KW + C_M_AXIS_TUSER_WIDTH + C_M_AXIS_DATA_WIDTH;
  localparam int unsigned CW = $clog2(OUT_FIFO_DEPTH) + 1;

  state_t        state, state_next;
  logic          inflight;
  logic          push, pop, admit, pkt_done;
  logic [CW-1:0] fifo_count, occ_next;
  logic          fifo_full, fifo_empty;
  logic [FW-1:0] fifo_dout;

  // A word lands exactly in the cycles spent in STREAM, so the flag is the state.
  assign inflight = (state == STREAM);
  assign push     = inflight;
  assign pop      = m_axis.tvalid & m_axis.tready;
  assign occ_next = fifo_count + CW'(push) - CW'(pop);
  assign admit    = (occ_next < CW'(OUT_FIFO_DEPTH));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and buffer read controls; held quiet while in reset.
  always_comb begin
    state_next             = state;
    s_axis_desc_tready     = 1'b0;
    m_buf_rd_first_word_en = 1'b0;
    m_buf_rd_en            = 1'b0;
    m_buf_rd_pkt_sop_addr  = '0;
    pkt_done               = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (s_axis_desc_tvalid && admit) begin
            s_axis_desc_tready     = 1'b1;
            m_buf_rd_first_word_en = 1'b1;
            m_buf_rd_en            = 1'b1;
            m_buf_rd_pkt_sop_addr  = s_axis_desc_tdata;
            state_next             = STREAM;
          end
        end
        STREAM: begin
          if (s_buf_tlast) begin
            pkt_done   = 1'b1;
            state_next = IDLE;
          end else if (admit) begin
            m_buf_rd_en = 1'b1;
          end else begin
            state_next = STALL;
          end
        end
        STALL: begin
          if (admit) begin
            m_buf_rd_en = 1'b1;
            state_next  = STREAM;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Completed-packet counter, wraps at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pkt_count <= '0;
    else if (pkt_done) pkt_count <= pkt_count + 32'd1;
  end

  // Admission control must never let a landing word hit a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_full && push && !pop));
  end

  axis_fwft_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({s_buf_tlast, s_buf_tkeep, s_buf_tuser, s_buf_tdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis.tvalid = ~fifo_empty;
  assign {m_axis.tlast, m_axis.tkeep, m_axis.tuser, m_axis.tdata} = fifo_dout;
  assign busy = (state != IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_pkt_buffer_reader.sv
// Scoreboard bench: behavioural linked-word buffer feeding the reader.
module tb_pkt_buffer_reader;
  import pkt_buffer_reader_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [11:0]  desc_tdata;
  logic         desc_tvalid;
  logic         desc_tready;
  logic         first_word_en, rd_en;
  logic [11:0]  sop_addr;
  logic [255:0] s_buf_tdata;
  logic [31:0]  s_buf_tkeep;
  logic         s_buf_tlast;
  logic [127:0] s_buf_tuser;
  logic         busy;
  logic [31:0]  pkt_count;

  pkt_buffer_reader_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) m_axis_if ();

  pkt_buffer_reader #(
    .ADDR_WIDTH           (12),
    .C_M_AXIS_DATA_WIDTH  (256),
    .C_M_AXIS_TUSER_WIDTH (128),
    .OUT_FIFO_DEPTH       (4)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_desc_tdata      (desc_tdata),
    .s_axis_desc_tvalid     (desc_tvalid),
    .s_axis_desc_tready     (desc_tready),
    .m_buf_rd_first_word_en (first_word_en),
    .m_buf_rd_en            (rd_en),
    .m_buf_rd_pkt_sop_addr  (sop_addr),
    .s_buf_tdata            (s_buf_tdata),
    .s_buf_tkeep            (s_buf_tkeep),
    .s_buf_tlast            (s_buf_tlast),
    .s_buf_tuser            (s_buf_tuser),
    .m_axis                 (m_axis_if),
    .busy                   (busy),
    .pkt_count              (pkt_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] wdata(input logic [11:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = {4'(i), 4'hA, 4'h0, a, 8'h5C};
    return r;
  endfunction

  function automatic logic [31:0] wkeep(input logic last);
    return last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [127:0] wuser(input logic [11:0] a);
    return {8'hEE, 4'h0, a, {13{8'h3C}}};
  endfunction

  function automatic logic [511:0] mk_beat(input logic [11:0] a, input logic last);
    logic [511:0] r;
    r = '0;
    r[416:0] = {last, wkeep(last), wuser(a), wdata(a)};
    return r;
  endfunction

  logic [511:0] q[$];
  int           len_tab[int];

  // Buffer model: one-cycle read latency, words of a packet linked at addr+1.
  logic [11:0] cur_a;
  int          cur_idx, cur_len, reads;
  bit          active;
  always @(posedge clk or posedge rst) begin
    logic [11:0] na;
    int          ni, nl, nr;
    logic        last;
    if (rst) begin
      active <= 1'b0; cur_a <= '0; cur_idx <= 0; cur_len <= 0; reads <= 0;
      s_buf_tdata <= '0; s_buf_tkeep <= '0; s_buf_tlast <= 1'b0; s_buf_tuser <= '0;
    end else if (first_word_en || rd_en) begin
      if (first_word_en) begin
        if (active) check_val("first_while_active", 1, 0);
        if (!rd_en) check_val("first_without_rd", 0, 1);
        na = sop_addr; ni = 0; nl = len_tab[int'(sop_addr)]; nr = 1;
      end else begin
        if (!active) check_val("rd_after_last", 1, 0);
        na = cur_a + 12'd1; ni = cur_idx + 1; nl = cur_len; nr = reads + 1;
      end
      last = (ni == nl - 1);
      if (last) check_val("reads_per_pkt", nr, nl);
      cur_a <= na; cur_idx <= ni; cur_len <= nl; reads <= nr; active <= !last;
      s_buf_tdata <= wdata(na); s_buf_tkeep <= wkeep(last);
      s_buf_tlast <= last;      s_buf_tuser <= wuser(na);
    end
  end

  // Downstream ready pattern generator.
  int cyc = 0;
  int rdy_mode = 0;
  int stall_from = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_axis_if.tready = cyc[0];
      2:       m_axis_if.tready = !(cyc >= stall_from && cyc < stall_from + 8);
      3:       m_axis_if.tready = 1'b0;
      default: m_axis_if.tready = 1'b1;
    endcase
  end

  // Output monitor and protocol watchers.
  int peak = 0;
  bit saw_stall = 0;
  always @(negedge clk) begin
    logic [511:0] got, exp;
    if (!rst) begin
      if (int'(dut.u_fifo.count) > peak) peak = int'(dut.u_fifo.count);
      if (dut.state == STALL) saw_stall = 1;
      if (dut.u_fifo.count == 4 && rd_en && !(m_axis_if.tvalid && m_axis_if.tready))
        check_val("rd_while_full", 1, 0);
      if (m_axis_if.tvalid && m_axis_if.tready) begin
        got = '0;
        got[416:0] = {m_axis_if.tlast, m_axis_if.tkeep, m_axis_if.tuser, m_axis_if.tdata};
        if (q.size() == 0) begin
          check_val("unexpected_beat", got, 0);
        end else begin
          exp = q.pop_front();
          check_val("beat", got, exp);
        end
      end
    end
  end

  task automatic send(input logic [11:0] sop, input int len);
    bit ok;
    len_tab[int'(sop)] = len;
    for (int i = 0; i < len; i++) q.push_back(mk_beat(sop + 12'(i), i == len - 1));
    desc_tdata  = sop;
    desc_tvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (desc_tready) ok = 1;
    end
    if (!ok) check_val("desc_timeout", 0, 1);
    @(posedge clk); #1;
    desc_tvalid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) ok = 1;
    end
    if (!ok) check_val("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    desc_tvalid = 1'b0;
    desc_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tvalid", m_axis_if.tvalid, 0);
    check_val("rst_desc_tready", desc_tready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_pkt_count", pkt_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(12'h010, 3);  drain();
    check_val("pkt_count_3w", pkt_count, 1);

    send(12'h040, 1);  drain();
    check_val("pkt_count_1w", pkt_count, 2);

    rdy_mode = 2; stall_from = cyc + 2;
    send(12'h080, 10); drain();
    check_val("pkt_count_stall", pkt_count, 3);
    check_val("fifo_peak_full", peak, 4);
    check_val("saw_stall", saw_stall, 1);

    rdy_mode = 0;
    send(12'h020, 4);
    send(12'h100, 2);  drain();
    check_val("pkt_count_b2b", pkt_count, 5);

    rdy_mode = 1;
    send(12'h300, 16); drain();
    check_val("pkt_count_toggle", pkt_count, 6);
    check_val("fifo_peak_le_depth", peak <= 4, 1);

    rdy_mode = 3;
    send(12'h200, 12);
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("arst_tvalid", m_axis_if.tvalid, 0);
    check_val("arst_tdata", m_axis_if.tdata, 0);
    check_val("arst_rd_en", rd_en, 0);
    check_val("arst_first", first_word_en, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_pkt_count", pkt_count, 0);
    check_val("arst_state", dut.state, IDLE);
    check_val("arst_fifo_count", dut.u_fifo.count, 0);
    q.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    send(12'h050, 2);  drain();
    check_val("pkt_count_after_rst", pkt_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    check_val("global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
